prog_loader: RTL and testbench

- Fills the CPU instruction memory from an external byte stream before the CPU runs.
- The CPU reads instruction memory; this block is the matching writer.
- Holds the CPU in reset while loading, then releases it once a valid image is written.
- Sits between a byte source (UART receiver or testbench) and the write port of the instruction ROM/RAM.

---
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Writes a framed byte image (HEADER, COUNT, hi/lo word bytes, XOR CHK) into instruction memory, holding the CPU until the image verifies.
// Write strobe fires one cycle after each word's low byte; in_ready drops in WRITE/DONE/ERR, so the source holds its byte.
module prog_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              count_q, count_d;
    logic [7:0]              chk_q, chk_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    in_ready_q, in_ready_d;
    logic                    wr_en_q, wr_en_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    take;
    logic                    last_word;

    assign take      = in_valid && in_ready_q;
    // mem_addr doubles as the word index within the frame
    assign last_word = ((32'(addr_q) + 32'd1) == 32'(count_q));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        chk_d   = chk_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (take && in_data == HEADER) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (take) begin
                    count_d = in_data;
                    addr_d  = '0;
                    chk_d   = '0;
                    state_d = (in_data == 8'd0) ? S_ERR : S_HI;
                end
            end
            S_HI: begin
                if (take) begin
                    wdata_d[DATA_WIDTH-1 -: 8] = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (take) begin
                    wdata_d[7:0] = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_HI;
                end
            end
            S_CHECK: begin
                if (take) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (restart) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q
        in_ready_d = (state_d == S_IDLE) || (state_d == S_COUNT) || (state_d == S_HI) ||
                     (state_d == S_LO)   || (state_d == S_CHECK);
        wr_en_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        hold_d     = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            chk_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            chk_q      <= chk_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign cpu_hold    = hold_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes/status, a monitor pops and compares.
module tb_prog_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    wr_t         wq[$];
    logic [2:0]  sq[$];
    logic [7:0]  tx_q[$];
    logic [31:0] stall_flags;
    logic        prev_done = 1'b0;
    logic        prev_err  = 1'b0;

    prog_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .HEADER(8'hA5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .restart     (restart),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write strobe and every done/error assertion against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_wr_en) begin
                    if (wq.size() == 0) begin
                        check("unexpected_write", {8'h0, mem_addr, mem_wr_data}, 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = wq.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(e.addr));
                        check("wr_data", 32'(mem_wr_data), 32'(e.data));
                        check("ready_in_write", 32'(in_ready), 32'd0);
                    end
                end
                if ((done && !prev_done) || (error && !prev_err)) begin
                    if (sq.size() == 0) begin
                        check("unexpected_status", {29'h0, done, error, cpu_hold}, 32'hFFFF_FFFF);
                    end else begin
                        logic [2:0] s;
                        s = sq.pop_front();
                        check("status_done_err_hold", {29'h0, done, error, cpu_hold}, {29'h0, s});
                    end
                end
            end
            prev_done = done;
            prev_err  = error;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output logic stalled);
        int t;
        t = 0;
        stalled = 1'b0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            stalled = 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("handshake_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Sends tx_q; bit i of gap_mask inserts one idle cycle after byte i
    task automatic send_frame(input logic [31:0] gap_mask);
        logic st;
        int   n;
        n = tx_q.size();
        stall_flags = '0;
        for (int i = 0; i < n; i++) begin
            send_byte(tx_q[i], st);
            if (i < 32) begin
                stall_flags[i] = st;
                if (gap_mask[i]) @(negedge clk);
            end
        end
        tx_q.delete();
    endtask

    task automatic wait_status();
        int t;
        t = 0;
        while (!(done || error) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("status_timeout", 32'(done || error), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_done", 32'(done), 32'd0);
        check("restart_error", 32'(error), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    initial begin
        // Reset for two cycles, outputs checked while reset is held
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Nominal: CHK = 12^34^AB^CD = 40
        wq.push_back('{8'h00, 16'h1234});
        wq.push_back('{8'h01, 16'hABCD});
        sq.push_back(3'b100);
        tx_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(32'h0);
        wait_status();
        do_restart();

        // Bad checksum: writes still happen, then error
        wq.push_back('{8'h00, 16'h1234});
        wq.push_back('{8'h01, 16'hABCD});
        sq.push_back(3'b011);
        tx_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame(32'h0);
        wait_status();
        do_restart();

        // Garbage then zero count: no writes, error after count byte
        sq.push_back(3'b011);
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00};
        send_frame(32'h0);
        wait_status();
        do_restart();

        // Gaps after bytes 0..2; CHK presented during WRITE must be held
        wq.push_back('{8'h00, 16'h8001});
        sq.push_back(3'b100);
        tx_q = '{8'hA5, 8'h01, 8'h80, 8'h01, 8'h81};
        send_frame(32'h7);
        check("chk_byte_held", 32'(stall_flags[4]), 32'd1);
        check("lo_byte_not_held", 32'(stall_flags[3]), 32'd0);
        wait_status();
        do_restart();

        // Reset after HI byte of word 1 of a 3-word frame
        wq.push_back('{8'h00, 16'h1122});
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame(32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        // Fresh frame: CHK = DE^AD^BE^EF = 22
        wq.push_back('{8'h00, 16'hDEAD});
        wq.push_back('{8'h01, 16'hBEEF});
        sq.push_back(3'b100);
        tx_q = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_frame(32'h0);
        wait_status();
        do_restart();

        // Max image: word i = {i, ~i}; each word XORs to FF, 255 words give CHK = FF
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'hFF);
        for (int i = 0; i < 255; i++) begin
            logic [7:0] hi;
            hi = 8'(i);
            wq.push_back('{hi, {hi, ~hi}});
            tx_q.push_back(hi);
            tx_q.push_back(~hi);
        end
        tx_q.push_back(8'hFF);
        sq.push_back(3'b100);
        send_frame(32'h0);
        wait_status();
        check("max_final_addr", 32'(mem_addr), 32'd254);

        repeat (5) @(negedge clk);
        check("writes_remaining", 32'(wq.size()), 32'd0);
        check("status_remaining", 32'(sq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
